// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, false-start rejection, framing check.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_8n1 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       parity_err
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic             rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             tick;
  logic             mid_bit;

  assign rx_s    = sync_q[1];
  assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
  assign mid_bit = tick && (os_cnt == OS_LAST);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so the shift chain cannot collapse into one flop.
      sync_q  <= {sync_q[0], rx_serial};
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      rx_busy     <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle; a branch below raises them for exactly one clk.
      rx_done     <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif

      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);

      if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);

      case (state)
        IDLE: begin
          rx_busy <= 1'b0;
          if (rx_prev && !rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
            os_cnt  <= '0;
            bit_cnt <= '0;
          end
        end

        START: begin
          if (tick && os_cnt == OS_MID) begin
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state  <= DATA;
              os_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (mid_bit) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid_bit) begin
            par_bad <= rx_s ^ (^shift);
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (mid_bit) begin
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
            par_bad    <= 1'b0;
`endif
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
                rx_data <= shift;
                rx_done <= 1'b1;
              end
`else
              rx_data <= shift;
              rx_done <= 1'b1;
`endif
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end

        // Break or stuck-low line: hold off until it returns high so one break gives one error.
        WAIT_HIGH: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: frames are built from bytes, expected bytes are queued,
// and an independent monitor pops and compares on every rx_done.
module tb_uart_rx_8n1;

  localparam int CLK_FREQ   = 16_000_000;
  localparam int BAUD       = 1_000_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       framing_err;
  logic       parity_err;

  uart_rx_8n1 #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .framing_err(framing_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] popped;
  int         fe_exp = 0, fe_seen = 0;
  int         pe_exp = 0, pe_seen = 0;
  int         done_seen = 0;
  bit         busy_seen = 1'b0;
  bit         busy_chk_pending = 1'b0;
  int         d0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy_chk_pending) begin
        check("busy_after_done", 32'(rx_busy), 32'd0);
        busy_chk_pending = 1'b0;
      end
      if (rx_busy)     busy_seen = 1'b1;
      if (framing_err) fe_seen++;
      if (parity_err)  pe_seen++;
      if (rx_done) begin
        done_seen++;
        busy_chk_pending = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rx_done: got data 0x%0h, expected no byte", rx_data);
        end else begin
          popped = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(popped));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Reference model: a frame yields a byte only if its stop bit is high and its parity (if any) is even.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    bit good;
    good = stop;
`ifdef UART_RX_PARITY_EN
    if (par_flip) begin
      good = 1'b0;
      pe_exp++;
    end
`endif
    if (!stop) fe_exp++;
    if (good) begin
      exp_q.push_back(d);
      last_good = d;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) begin end
`endif
    send_bit(stop);
  endtask

  task automatic wait_quiet(input string name);
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !rx_busy) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"},     32'(rx_data),     32'd0);
    check({tag, "_rx_done"},     32'(rx_done),     32'd0);
    check({tag, "_rx_busy"},     32'(rx_busy),     32'd0);
    check({tag, "_framing_err"}, 32'(framing_err), 32'd0);
    check({tag, "_parity_err"},  32'(parity_err),  32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, flip;
    int         gap;

    @(negedge clk);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single good byte
    send_frame(8'h4F, 1'b1, 1'b0);
    wait_quiet("good_drain");
    check("good_rx_data", 32'(rx_data), 32'h4F);
    check("good_fe_count", 32'(fe_seen), 32'(fe_exp));

    // Back-to-back message plus CRC byte, no idle gap
    d0 = done_seen;
    send_frame(8'h4F, 1'b1, 1'b0);
    send_frame(8'h4C, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    rx_serial = 1'b1;
    wait_quiet("b2b_drain");
    check("b2b_done_count", 32'(done_seen - d0), 32'd4);
    check("b2b_fe_count", 32'(fe_seen), 32'(fe_exp));

    // False start: 5 clk low glitch
    busy_seen = 1'b0;
    d0 = done_seen;
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    repeat (40) @(negedge clk);
    check("false_busy_seen", 32'(busy_seen), 32'd1);
    check("false_busy_idle", 32'(rx_busy), 32'd0);
    check("false_no_done", 32'(done_seen - d0), 32'd0);
    check("false_fe_count", 32'(fe_seen), 32'(fe_exp));
    check("false_rx_data", 32'(rx_data), 32'(last_good));

    // Framing error followed by a break, then recovery
    d0 = done_seen;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    check("frame_fe_count", 32'(fe_seen), 32'(fe_exp));
    check("frame_no_done", 32'(done_seen - d0), 32'd0);
    check("frame_rx_data_kept", 32'(rx_data), 32'(last_good));
    send_frame(8'h81, 1'b1, 1'b0);
    wait_quiet("recover_drain");
    check("recover_rx_data", 32'(rx_data), 32'h81);

    // Reset during data bit 3 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    repeat (BIT_CLK / 2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    last_good = 8'h00;
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_quiet("postreset_drain");
    check("postreset_rx_data", 32'(rx_data), 32'h12);

`ifdef UART_RX_PARITY_EN
    d0 = done_seen;
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    rx_serial = 1'b1;
    wait_quiet("parity_drain");
    check("parity_done_count", 32'(done_seen - d0), 32'd1);
    check("parity_rx_data", 32'(rx_data), 32'h07);
    check("parity_pe_count", 32'(pe_seen), 32'(pe_exp));
`endif

    // Randomized frames with occasional bad stop / parity bits and random idle gaps
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      flip = stop && ($urandom_range(0, 7) == 0);
      gap  = stop ? $urandom_range(0, 20) : $urandom_range(2, 20);
      send_frame(d, stop, flip);
      rx_serial = 1'b1;
      repeat (gap) @(negedge clk);
    end
    wait_quiet("random_drain");
    check("random_fe_count", 32'(fe_seen), 32'(fe_exp));
    check("random_pe_count", 32'(pe_seen), 32'(pe_exp));
    check("final_rx_data", 32'(rx_data), 32'(last_good));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
